// File: rtl/popcount_pkg.sv
// -----------------------------------------------------------------------------
// popcount_pkg
// Shared definitions for the population-count datapath:
//   - popcount_acc_state_t : FSM state encoding of the frame accumulator.
//   - popcount_cnt_width() : width of a per-word ones count (0..DATA_WIDTH).
//     The combinational counter's count_o uses the same width.
//   - popcount_acc_width() : width of a frame total that cannot wrap for
//                            MAX_WORDS words of DATA_WIDTH bits.
//   - popcount_words_width(): width of a word counter that can hold MAX_WORDS.
// -----------------------------------------------------------------------------
package popcount_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } popcount_acc_state_t;

  localparam int POPCOUNT_DEFAULT_DATA_WIDTH = 32;
  localparam int POPCOUNT_DEFAULT_MAX_WORDS  = 256;

  // A DATA_WIDTH-bit word holds up to DATA_WIDTH ones, which needs one bit
  // more than log2(DATA_WIDTH) for a power-of-two width.
  function automatic int popcount_cnt_width(input int data_width);
    return $clog2(data_width) + 1;
  endfunction

  function automatic int popcount_acc_width(input int data_width, input int max_words);
    return popcount_cnt_width(data_width) + $clog2(max_words);
  endfunction

  function automatic int popcount_words_width(input int max_words);
    return $clog2(max_words) + 1;
  endfunction

endpackage

// File: rtl/population_count_accumulator.sv
// -----------------------------------------------------------------------------
// population_count_accumulator
// Sums the per-word ones counts of a frame of words (delimited by last_i) and
// presents the frame total and word count on a registered valid/ready output.
//
// Ports:
//   clk_i      in   clock, rising edge
//   rst_i      in   asynchronous reset, active-high
//   count_i    in   per-word ones count, CNT_WIDTH bits, range 0..DATA_WIDTH
//   valid_i    in   count_i valid
//   last_i     in   beat is the final word of the frame
//   ready_o    out  block can accept a beat (low only while a result is held)
//   total_o    out  frame ones total, ACC_WIDTH bits
//   words_o    out  words accepted in the frame (saturates at MAX_WORDS)
//   overflow_o out  frame had more than MAX_WORDS words; total covers the first
//                   MAX_WORDS only
//   valid_o    out  total_o / words_o / overflow_o valid
//   ready_i    in   downstream accepts the result
//   flush_i    in   abandon the current frame (only with POPCOUNT_ACC_FLUSH_EN)
//
// Build option: define POPCOUNT_ACC_FLUSH_EN to add flush_i. Without it a frame
// ends only by last_i or reset.
// -----------------------------------------------------------------------------
module population_count_accumulator
  import popcount_pkg::*;
#(
  parameter int DATA_WIDTH = POPCOUNT_DEFAULT_DATA_WIDTH,
  parameter int MAX_WORDS  = POPCOUNT_DEFAULT_MAX_WORDS,
  parameter int CNT_WIDTH  = popcount_cnt_width(DATA_WIDTH),
  parameter int ACC_WIDTH  = popcount_acc_width(DATA_WIDTH, MAX_WORDS)
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [CNT_WIDTH-1:0]                     count_i,
  input  logic                                     valid_i,
  input  logic                                     last_i,
  output logic                                     ready_o,
`ifdef POPCOUNT_ACC_FLUSH_EN
  input  logic                                     flush_i,
`endif
  output logic [ACC_WIDTH-1:0]                     total_o,
  output logic [popcount_words_width(MAX_WORDS)-1:0] words_o,
  output logic                                     overflow_o,
  output logic                                     valid_o,
  input  logic                                     ready_i
);

  localparam int WORDS_WIDTH = popcount_words_width(MAX_WORDS);
  localparam logic [WORDS_WIDTH-1:0] MAX_WORDS_W = WORDS_WIDTH'(MAX_WORDS);

  popcount_acc_state_t     r_state;
  logic [ACC_WIDTH-1:0]    r_acc;
  logic [WORDS_WIDTH-1:0]  r_words;
  logic                    r_overflow;

  logic                    w_accept;
  logic                    w_room;
  logic [ACC_WIDTH-1:0]    w_count_ext;

  // ready/valid decode straight from the state register, so both are glitch-free
  // register outputs and the single DONE cycle forms the per-frame bubble.
  assign ready_o     = (r_state != DONE);
  assign valid_o     = (r_state == DONE);
  assign w_accept    = valid_i & ready_o;
  assign w_room      = (r_words < MAX_WORDS_W);
  assign w_count_ext = ACC_WIDTH'(count_i);

  assign total_o    = r_acc;
  assign words_o    = r_words;
  assign overflow_o = r_overflow;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_words    <= '0;
      r_overflow <= 1'b0;
    end else begin
`ifdef POPCOUNT_ACC_FLUSH_EN
      // Flush wins over a coincident beat and over a DONE handshake.
      if (flush_i) begin
        r_state    <= IDLE;
        r_acc      <= '0;
        r_words    <= '0;
        r_overflow <= 1'b0;
      end else
`endif
      begin
        case (r_state)
          IDLE: begin
            // Result registers keep the previous frame until the first beat.
            if (w_accept) begin
              r_acc      <= w_count_ext;
              r_words    <= WORDS_WIDTH'(1);
              r_overflow <= 1'b0;
              r_state    <= last_i ? DONE : ACCUM;
            end
          end
          ACCUM: begin
            if (w_accept) begin
              if (w_room) begin
                r_acc   <= r_acc + w_count_ext;
                r_words <= r_words + WORDS_WIDTH'(1);
              end else begin
                // Beyond MAX_WORDS the word is dropped and the frame is marked.
                r_overflow <= 1'b1;
              end
              if (last_i) begin
                r_state <= DONE;
              end
            end
          end
          DONE: begin
            if (ready_i) begin
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_population_count_accumulator.sv
module tb_population_count_accumulator;
  import popcount_pkg::*;

  localparam int DW = 32;
  localparam int MW = 4;
  localparam int CW = popcount_cnt_width(DW);
  localparam int AW = popcount_acc_width(DW, MW);
  localparam int WW = popcount_words_width(MW);

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [CW-1:0] count_i;
  logic          valid_i;
  logic          last_i;
  logic          ready_o;
  logic [AW-1:0] total_o;
  logic [WW-1:0] words_o;
  logic          overflow_o;
  logic          valid_o;
  logic          ready_i;
`ifdef POPCOUNT_ACC_FLUSH_EN
  logic          flush_i;
`endif

  typedef struct packed {
    logic [AW-1:0] total;
    logic [WW-1:0] words;
    logic          ovf;
  } res_t;

  res_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  population_count_accumulator #(
    .DATA_WIDTH(DW),
    .MAX_WORDS (MW)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .count_i   (count_i),
    .valid_i   (valid_i),
    .last_i    (last_i),
    .ready_o   (ready_o),
`ifdef POPCOUNT_ACC_FLUSH_EN
    .flush_i   (flush_i),
`endif
    .total_o   (total_o),
    .words_o   (words_o),
    .overflow_o(overflow_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic res_t mk(input int t, input int w, input bit o);
    res_t r;
    r.total = AW'(t);
    r.words = WW'(w);
    r.ovf   = o;
    return r;
  endfunction

  // Entered and left at posedge+1. Holds the beat until it is accepted.
  task automatic beat(input int c, input bit l);
    int n;
    n       = 0;
    count_i = CW'(c);
    last_i  = l;
    valid_i = 1'b1;
    @(negedge clk_i);
    while (!ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    if (!ready_o) check("beat_accept_timeout", 0, 1);
    $display("beat count=%0d last=%0d", c, l);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  // Called right after the last beat (ready_i high): result next cycle, one bubble.
  task automatic done_bubble(input string name, input int total);
    @(negedge clk_i);
    check({name, "_valid_latency"}, int'(valid_o), 1);
    check({name, "_bubble_ready"}, int'(ready_o), 0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check({name, "_valid_drop"}, int'(valid_o), 0);
    check({name, "_ready_back"}, int'(ready_o), 1);
    check({name, "_total_hold"}, int'(total_o), total);
    @(posedge clk_i); #1;
  endtask

  // Scoreboard monitor: compares on each output handshake.
  initial begin
    res_t e;
    forever begin
      @(negedge clk_i);
      if (!rst_i && valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got total %0d words %0d, required no result",
                   total_o, words_o);
        end else begin
          e = exp_q.pop_front();
          $display("result total=%0d words=%0d overflow=%0d", total_o, words_o, overflow_o);
          check("sb_total", int'(total_o), int'(e.total));
          check("sb_words", int'(words_o), int'(e.words));
          check("sb_overflow", int'(overflow_o), int'(e.ovf));
        end
      end
    end
  end

  initial begin
    rst_i   = 1'b1;
    valid_i = 1'b0;
    last_i  = 1'b0;
    count_i = '0;
    ready_i = 1'b1;
`ifdef POPCOUNT_ACC_FLUSH_EN
    flush_i = 1'b0;
`endif
    repeat (2) @(negedge clk_i);
    check("rst_total", int'(total_o), 0);
    check("rst_words", int'(words_o), 0);
    check("rst_overflow", int'(overflow_o), 0);
    check("rst_valid", int'(valid_o), 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_ready", int'(ready_o), 1);
    @(posedge clk_i); #1;

    // Four-beat frame, exactly MAX_WORDS: 32+0+17+5 = 54.
    exp_q.push_back(mk(54, 4, 1'b0));
    beat(32, 0); beat(0, 0); beat(17, 0); beat(5, 1);
    done_bubble("frame4", 54);

    // Single-beat frame.
    exp_q.push_back(mk(8, 1, 1'b0));
    beat(8, 1);
    done_bubble("single", 8);

    // Backpressure: 1+2+7 = 10 held for 5 cycles while a beat waits.
    ready_i = 1'b0;
    exp_q.push_back(mk(10, 3, 1'b0));
    beat(1, 0); beat(2, 0); beat(7, 1);
    count_i = CW'(9);
    last_i  = 1'b1;
    valid_i = 1'b1;
    repeat (5) begin
      @(negedge clk_i);
      check("bp_valid", int'(valid_o), 1);
      check("bp_ready", int'(ready_o), 0);
      check("bp_total", int'(total_o), 10);
      check("bp_words", int'(words_o), 3);
      @(posedge clk_i); #1;
    end
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("bp_idle_ready", int'(ready_o), 1);
    check("bp_idle_total", int'(total_o), 10);
    exp_q.push_back(mk(9, 1, 1'b0));
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    last_i  = 1'b0;
    $display("beat count=9 last=1");
    @(negedge clk_i);
    check("bp_next_valid", int'(valid_o), 1);
    check("bp_next_total", int'(total_o), 9);
    @(posedge clk_i); #1;

    // Overflow: six beats of 32, only four counted.
    exp_q.push_back(mk(128, 4, 1'b1));
    repeat (5) beat(32, 0);
    beat(32, 1);
    done_bubble("ovf", 128);
    beat(5, 0);
    @(negedge clk_i);
    check("ovf_cleared", int'(overflow_o), 0);
    check("ovf_next_words", int'(words_o), 1);
    check("ovf_next_total", int'(total_o), 5);
    @(posedge clk_i); #1;
    beat(6, 0); beat(7, 0);

    // Asynchronous reset mid-frame: outputs clear without waiting for a clock.
    #2 rst_i = 1'b1;
    #1;
    check("arst_total", int'(total_o), 0);
    check("arst_words", int'(words_o), 0);
    check("arst_overflow", int'(overflow_o), 0);
    check("arst_valid", int'(valid_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    exp_q.push_back(mk(7, 2, 1'b0));
    beat(3, 0); beat(4, 1);
    done_bubble("post_rst", 7);

`ifdef POPCOUNT_ACC_FLUSH_EN
    // Flush coincident with a third beat: beat dropped, no result.
    beat(2, 0); beat(3, 0);
    count_i = CW'(4);
    valid_i = 1'b1;
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    flush_i = 1'b0;
    $display("flush with beat count=4");
    @(negedge clk_i);
    check("flush_valid", int'(valid_o), 0);
    check("flush_ready", int'(ready_o), 1);
    check("flush_words", int'(words_o), 0);
    check("flush_total", int'(total_o), 0);
    @(posedge clk_i); #1;
    exp_q.push_back(mk(1, 1, 1'b0));
    beat(1, 1);
    done_bubble("post_flush", 1);
`endif

    repeat (3) @(negedge clk_i);
    check("sb_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/population_count_accumulator.md
Name: population_count_accumulator

Overview:
- Sequential stage directly downstream of the combinational population counter.
- Consumes one per-word bit count per accepted beat and accumulates a frame total over a stream of words delimited by last_i.
- Presents the frame total and word count on a registered valid/ready output.
- Together with the upstream counter, it implements popcount over operands wider than one word.

Parameters:
- DATA_WIDTH, 32, bits per word counted upstream (power of 2).
- MAX_WORDS, 256, maximum words per frame (power of 2, >= 2).
- CNT_WIDTH, $clog2(DATA_WIDTH)+1, width of the per-word count (derived, do not override).
- ACC_WIDTH, CNT_WIDTH+$clog2(MAX_WORDS), width of the frame total (derived).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- count_i  in  CNT_WIDTH  per-word ones count from the upstream counter, range 0..DATA_WIDTH.
- valid_i  in  1  count_i valid.
- last_i  in  1  beat is the final word of the frame.
- ready_o  out  1  block can accept a beat.
- total_o  out  ACC_WIDTH  frame ones total.
- words_o  out  $clog2(MAX_WORDS)+1  words accepted in the frame.
- overflow_o  out  1  frame exceeded MAX_WORDS; total covers the first MAX_WORDS words only.
- valid_o  out  1  total_o, words_o and overflow_o valid.
- ready_i  in  1  downstream accepts the result.
- flush_i  in  1  present only with POPCOUNT_ACC_FLUSH_EN.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE.
  - total_o = 0, words_o = 0, overflow_o = 0, valid_o = 0.
  - ready_o = 1 once reset is released.
- Input handshake: a beat is accepted on a rising edge with valid_i & ready_o. No beat is accepted otherwise. Inputs are sampled only at acceptance.
- FSM has states IDLE, ACCUM and DONE. ready_o = 1 in IDLE and ACCUM, 0 in DONE. valid_o = 1 only in DONE.
- IDLE, on accept: acc <= count_i, words <= 1, overflow <= 0. Next state is DONE if last_i, else ACCUM.
- ACCUM, on accept with words < MAX_WORDS: acc <= acc + count_i (zero-extended), words <= words + 1.
- ACCUM, on accept with words == MAX_WORDS: count_i is discarded, words holds at MAX_WORDS, overflow <= 1 (sticky for the frame).
- ACCUM, on accept with last_i: apply the update above, then go to DONE.
- DONE: outputs hold stable while ready_i = 0. On ready_i = 1, go to IDLE next cycle; the output registers keep their last value and valid_o drops.
- Latency: the result is valid the cycle after the last beat is accepted. There is one bubble cycle (ready_o = 0) per frame. The peak rate is one word per cycle inside a frame.
- Arithmetic: ACC_WIDTH is sized so that MAX_WORDS * DATA_WIDTH never wraps. count_i > DATA_WIDTH is illegal input; the result is undefined and the block does not check it.
- valid_i = 0 in ACCUM: the state and accumulator are held indefinitely, with no timeout.
- Reset mid-frame: all accumulated data is lost and no result is emitted.
- Single-word frame (last_i on the first beat) gives valid_o next cycle with words_o = 1.

Optional Feature:
- POPCOUNT_ACC_FLUSH_EN defined:
  - Adds port flush_i.
  - flush_i = 1 at a rising edge forces IDLE and clears acc, words and overflow. It also drops valid_o. No result is emitted.
  - flush_i has priority over a simultaneous accept (the beat is dropped) and over a DONE handshake.
- POPCOUNT_ACC_FLUSH_EN undefined: there is no flush_i port and a frame ends only by last_i or reset.

Decomposition:
- Shared package popcount_pkg holds:
  - state enum popcount_acc_state_t {IDLE, ACCUM, DONE}.
  - Width helper constants or functions for CNT_WIDTH and ACC_WIDTH, also used by the combinational counter's count_o width.
- No sub-module. The integration level connects population_count_combinational count_o to count_i.

Test Plan:
- Frame of 4 beats with count_i = 32, 0, 17, 5 and last_i on beat 4, ready_i = 1 -> valid_o one cycle after beat 4, total_o = 54, words_o = 4, overflow_o = 0.
- Single-beat frame count_i = 8 with last_i -> next cycle total_o = 8, words_o = 1; ready_o = 0 for exactly one cycle.
- Backpressure: ready_i = 0 for 5 cycles in DONE -> outputs stable, ready_o = 0 throughout, valid_i beats not accepted; the first beat is accepted one cycle after ready_i rises.
- MAX_WORDS = 4, 6 beats of count_i = 32 -> total_o = 128, words_o = 4, overflow_o = 1. The next frame starts with overflow_o cleared.
- rst_i asserted asynchronously mid-ACCUM after 3 beats -> all outputs 0 immediately. A new 2-beat frame of 3 and 4 gives total_o = 7.
- With POPCOUNT_ACC_FLUSH_EN: flush_i after 2 beats, coincident with a third valid beat -> IDLE, beat dropped, no valid_o. The next frame of count_i = 1 with last_i gives total_o = 1.
